mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port_pkg.sv | 31 +++
 rtl/mem_port_byte_lane.sv | 46 ++++
 rtl/mem_port.sv | 165 ++++++++++++++++
 tb/tb_mem_port.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared encodings for the byte-serial memory port: request-code fields,
// length codes, FSM state constants and the byte-count helper.
package mem_port_pkg;

  localparam int ME_EN     = 4;
  localparam int ME_LEN_HI = 3;
  localparam int ME_LEN_LO = 2;
  localparam int ME_WR     = 1;
  localparam int ME_SX     = 0;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  // State set {IDLE, ACC, DONE}, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The unused code 2'b10 is folded into a full word access.
  function automatic logic [2:0] byteCount(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_port_byte_lane.sv
// mem_byte_lane: collects load bytes one at a time (little-endian) and
// presents them zero- or sign-extended to 32 bits.
module mem_byte_lane
  import mem_port_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [1:0]  index_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  len_i,
  input  logic        signExt_i,
  output logic [31:0] data_o
);

  logic [31:0] raw_q;
  logic [31:0] raw_d;

  always_comb begin
    raw_d = raw_q;
    if (clear_i) begin
      raw_d = '0;
    end else if (capture_i) begin
      raw_d[{index_i, 3'b000} +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

  always_comb begin
    data_o = raw_q;
    case (len_i)
      LEN_BYTE: data_o = {{24{signExt_i & raw_q[7]}}, raw_q[7:0]};
      LEN_HALF: data_o = {{16{signExt_i & raw_q[15]}}, raw_q[15:0]};
      default:  data_o = raw_q;
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// mem_port: sequences byte/half/word loads and stores over a byte-wide RAM,
// stalling the pipeline while the access is in flight.
module mem_port
  import mem_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_e,
  input  logic [31:0] mem_a,
  input  logic [31:0] mem_n,
  input  logic [4:0]  wa,
  input  logic        we,
  output logic [31:0] res_o,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic        stall,
  output logic        done,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [ME_LEN_HI:0] ctl_q, ctl_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [4:0]        wa_q, wa_d;
  logic              we_q, we_d;
  logic [31:0]       ramA_q, ramA_d;
  logic              ramWr_q, ramWr_d;
  logic [7:0]        ramDout_q, ramDout_d;

  logic        accept;
  logic        inAcc;
  logic        isStore;
  logic [2:0]  nBytes;
  logic [2:0]  lastK;
  logic [2:0]  kNext;
  logic        accEnd;
  logic        capture;
  logic [1:0]  laneIdx;
  logic [31:0] laneData;

  assign inAcc   = (state_q == ST_ACC);
  assign accept  = !inAcc && mem_e[ME_EN];
  assign isStore = ctl_q[ME_WR];
  assign nBytes  = byteCount(ctl_q[ME_LEN_HI:ME_LEN_LO]);
  // Loads need one extra ACC cycle because RAM data trails the address.
  assign lastK   = isStore ? (nBytes - 3'd1) : nBytes;
  assign kNext   = k_q + 3'd1;
  assign accEnd  = inAcc && (k_q == lastK);
  assign capture = inAcc && !isStore && (k_q != 3'd0);
  assign laneIdx = k_q[1:0] - 2'd1;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ctl_d     = ctl_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wa_d      = wa_q;
    we_d      = we_q;
    ramA_d    = ramA_q;
    ramWr_d   = 1'b0;
    ramDout_d = ramDout_q;
    if (inAcc) begin
      if (accEnd) begin
        state_d = ST_DONE;
      end else begin
        k_d     = kNext;
        ramA_d  = addr_q + {29'd0, kNext};
        ramWr_d = isStore;
        if (isStore) begin
          ramDout_d = data_q[{kNext[1:0], 3'b000} +: 8];
        end
      end
    end else if (accept) begin
      state_d = ST_ACC;
      k_d     = 3'd0;
      ctl_d   = mem_e[ME_LEN_HI:0];
      addr_d  = mem_a;
      data_d  = mem_n;
      wa_d    = wa;
      we_d    = we;
      ramA_d  = mem_a;
      ramWr_d = mem_e[ME_WR];
      if (mem_e[ME_WR]) begin
        ramDout_d = mem_n[7:0];
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      ctl_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wa_q      <= '0;
      we_q      <= 1'b0;
      ramA_q    <= '0;
      ramWr_q   <= 1'b0;
      ramDout_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ctl_q     <= ctl_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wa_q      <= wa_d;
      we_q      <= we_d;
      ramA_q    <= ramA_d;
      ramWr_q   <= ramWr_d;
      ramDout_q <= ramDout_d;
    end
  end

  mem_byte_lane u_lane (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (accept),
    .capture_i (capture),
    .index_i   (laneIdx),
    .byte_i    (ram_din),
    .len_i     (ctl_q[ME_LEN_HI:ME_LEN_LO]),
    .signExt_i (ctl_q[ME_SX]),
    .data_o    (laneData)
  );

  // A request waiting in IDLE is stalled, so its writeback is suppressed.
  always_comb begin
    res_o = mem_a;
    wa_o  = wa;
    we_o  = we;
    case (state_q)
      ST_ACC: begin
        res_o = addr_q;
        wa_o  = wa_q;
        we_o  = 1'b0;
      end
      ST_DONE: begin
        res_o = isStore ? addr_q : laneData;
        wa_o  = wa_q;
        we_o  = isStore ? 1'b0 : we_q;
      end
      default: begin
        if (mem_e[ME_EN]) begin
          we_o = 1'b0;
        end
      end
    endcase
  end

  assign stall    = inAcc || accept;
  assign done     = (state_q == ST_DONE);
  assign ram_a    = ramA_q;
  assign ram_wr   = ramWr_q;
  assign ram_dout = ramDout_q;

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: directed and randomized accesses against a byte-array
// reference model of memory and the expected writeback results.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_e;
  logic [31:0] mem_a;
  logic [31:0] mem_n;
  logic [4:0]  wa;
  logic        we;
  logic [31:0] res_o;
  logic [4:0]  wa_o;
  logic        we_o;
  logic        stall;
  logic        done;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  always #5 clk = ~clk;

  mem_port dut (
    .clk      (clk),
    .rst      (rst),
    .mem_e    (mem_e),
    .mem_a    (mem_a),
    .mem_n    (mem_n),
    .wa       (wa),
    .we       (we),
    .res_o    (res_o),
    .wa_o     (wa_o),
    .we_o     (we_o),
    .stall    (stall),
    .done     (done),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
  );

  logic [7:0] ram    [logic [31:0]];
  logic [7:0] refMem [logic [31:0]];

  // Byte-wide synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin : ramModel
    logic [7:0] rd;
    rd = ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= rd;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] expRes;
  logic [4:0]  expWa;
  logic        expWe;
  int          expLat;
  logic [31:0] expWrA [$];
  logic [7:0]  expWrD [$];
  logic [31:0] lastRamA = 32'd0;
  logic [7:0]  lastDout = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]    = b;
    refMem[a] = b;
  endtask

  task automatic applyStimulus(input logic [4:0] e, input logic [31:0] a, input logic [31:0] n,
                               input logic [4:0] w, input logic wen);
    int nb;
    logic [31:0] v;
    mem_e = e;
    mem_a = a;
    mem_n = n;
    wa    = w;
    we    = wen;
    nb = (e[3:2] == 2'b00) ? 1 : (e[3:2] == 2'b01) ? 2 : 4;
    expWa = w;
    expWrA.delete();
    expWrD.delete();
    if (e[1]) begin
      expRes = a;
      expWe  = 1'b0;
      expLat = nb;
      for (int i = 0; i < nb; i++) begin
        expWrA.push_back(a + 32'(i));
        expWrD.push_back(n[8*i +: 8]);
        refMem[a + 32'(i)] = n[8*i +: 8];
      end
      lastRamA = a + 32'(nb - 1);
      lastDout = n[8*(nb-1) +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) begin
        v = v | ({24'd0, refRead(a + 32'(i))} << (8*i));
      end
      if (e[0] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      expRes = v;
      expWe  = wen;
      expLat = nb + 1;
      lastRamA = a + 32'(nb);
    end
    #1;
    check("stallOnAccept", 32'(stall), 32'd1);
  endtask

  task automatic checkOutput();
    int cyc;
    int stallCnt;
    logic [31:0] wrA [$];
    logic [7:0]  wrD [$];
    int m;
    @(posedge clk);
    #1;
    mem_e = 5'd0;
    cyc = 0;
    stallCnt = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (stall) stallCnt++;
      if (ram_wr) begin
        wrA.push_back(ram_a);
        wrD.push_back(ram_dout);
      end
    end
    check("latency", 32'(cyc), 32'(expLat));
    check("stallCycles", 32'(stallCnt), 32'(expLat));
    check("donePulse", 32'(done), 32'd1);
    check("result", res_o, expRes);
    check("waOut", 32'(wa_o), 32'(expWa));
    check("weOut", 32'(we_o), 32'(expWe));
    check("stallInDone", 32'(stall), 32'd0);
    check("ramWrInDone", 32'(ram_wr), 32'd0);
    check("writeCount", 32'(wrA.size()), 32'(expWrA.size()));
    m = (wrA.size() < expWrA.size()) ? wrA.size() : expWrA.size();
    for (int i = 0; i < m; i++) begin
      check("writeAddr", wrA[i], expWrA[i]);
      check("writeData", 32'(wrD[i]), 32'(expWrD[i]));
    end
  endtask

  task automatic idleCheck();
    logic [31:0] a;
    logic [4:0]  w;
    logic        wen;
    a   = $urandom;
    w   = 5'($urandom);
    wen = 1'($urandom);
    mem_e = {1'b0, 4'($urandom)};
    mem_a = a;
    wa    = w;
    we    = wen;
    #1;
    check("idleRes", res_o, a);
    check("idleWa", 32'(wa_o), 32'(w));
    check("idleWe", 32'(we_o), 32'(wen));
    check("idleDone", 32'(done), 32'd0);
    check("idleStall", 32'(stall), 32'd0);
    check("idleRamWr", 32'(ram_wr), 32'd0);
    check("idleRamAHold", ram_a, lastRamA);
    check("idleDoutHold", 32'(ram_dout), 32'(lastDout));
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] oldRes;
    logic [31:0] a;
    logic [1:0]  len;
    logic        chain;
    int          doneCnt;

    rst   = 1'b0;
    mem_e = 5'd0;
    mem_a = 32'd0;
    mem_n = 32'd0;
    wa    = 5'd0;
    we    = 1'b0;

    for (int i = 0; i < 16'h104; i++) preload(32'h0000_1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      preload(32'hFFFF_FFF8 + 32'(i), 8'($urandom));
      preload(32'(i), 8'($urandom));
    end

    repeat (2) @(negedge clk);
    check("rstStall", 32'(stall), 32'd0);
    check("rstDone", 32'(done), 32'd0);
    check("rstRamWr", 32'(ram_wr), 32'd0);
    check("rstRamA", ram_a, 32'd0);
    check("rstDout", 32'(ram_dout), 32'd0);
    rst = 1'b1;

    @(negedge clk);
    idleCheck();

    // Signed byte load
    preload(32'h100, 8'h80);
    applyStimulus(5'b10001, 32'h100, 32'd0, 5'd7, 1'b1);
    checkOutput();
    check("loadByteLit", res_o, 32'hFFFF_FF80);

    // Word load
    preload(32'h200, 8'h11);
    preload(32'h201, 8'h22);
    preload(32'h202, 8'h33);
    preload(32'h203, 8'h44);
    @(negedge clk);
    idleCheck();
    applyStimulus(5'b11100, 32'h200, 32'd0, 5'd9, 1'b1);
    checkOutput();
    check("loadWordLit", res_o, 32'h4433_2211);

    // Half store
    @(negedge clk);
    idleCheck();
    applyStimulus(5'b10110, 32'h300, 32'hAABB_CCDD, 5'd4, 1'b1);
    checkOutput();

    // Word store wrapping past the top of the address space
    @(negedge clk);
    idleCheck();
    applyStimulus(5'b11110, 32'hFFFF_FFFE, 32'h0102_0304, 5'd2, 1'b1);
    checkOutput();

    // Half load presented during DONE
    oldRes = expRes;
    applyStimulus(5'b10100, 32'h300, 32'd0, 5'd12, 1'b1);
    check("b2bDoneHeld", 32'(done), 32'd1);
    check("b2bResHeld", res_o, oldRes);
    checkOutput();
    check("b2bLoadLit", res_o, 32'h0000_CCDD);

    // Reset during byte 1 of a word store
    preload(32'h400, 8'hA0);
    preload(32'h401, 8'hA1);
    preload(32'h402, 8'hA2);
    preload(32'h403, 8'hA3);
    @(negedge clk);
    applyStimulus(5'b11110, 32'h400, 32'h5566_7788, 5'd3, 1'b1);
    refMem[32'h402] = 8'hA2;
    refMem[32'h403] = 8'hA3;
    @(posedge clk);
    #1;
    mem_e = 5'd0;
    @(negedge clk);
    @(negedge clk);
    check("abortRamWrK1", 32'(ram_wr), 32'd1);
    check("abortRamAK1", ram_a, 32'h401);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abortRamWr", 32'(ram_wr), 32'd0);
    check("abortStall", 32'(stall), 32'd0);
    check("abortDone", 32'(done), 32'd0);
    check("abortRamA", ram_a, 32'd0);
    check("abortDout", 32'(ram_dout), 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    check("abortNoDone", 32'(doneCnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("abortRam", 32'(ram[32'h400 + 32'(i)]), 32'(refMem[32'h400 + 32'(i)]));
    end
    lastRamA = 32'd0;
    lastDout = 8'd0;

    // Randomized accesses, some issued back-to-back during DONE
    for (int it = 0; it < 40; it++) begin
      len   = 2'($urandom);
      a     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                          : (32'h0000_1000 + 32'($urandom_range(0, 200)));
      chain = (it > 0) && ($urandom_range(0, 1) == 1);
      if (!chain) begin
        @(negedge clk);
        idleCheck();
        applyStimulus({1'b1, len, 1'($urandom), 1'($urandom)}, a, $urandom, 5'($urandom), 1'($urandom));
      end else begin
        oldRes = expRes;
        applyStimulus({1'b1, len, 1'($urandom), 1'($urandom)}, a, $urandom, 5'($urandom), 1'($urandom));
        check("randDoneHeld", 32'(done), 32'd1);
        check("randResHeld", res_o, oldRes);
      end
      checkOutput();
    end

    @(negedge clk);
    idleCheck();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
